// File: rtl/route_table.sv
// route_table
//   Per-router routing table: maps a destination router id to an output port.
//   The table is loaded through INIT/WRITE/LOAD/DATA while in LOAD state and
//   serves LOOKUP_CNT independent, registered lookup channels in RUN state.
//
// Ports
//   CLK, RESET          clock, synchronous active-high reset
//   INIT                configuration request (IDLE/RUN -> LOAD, LOAD -> RUN when low)
//   WRITE, LOAD, DATA   entry write strobe, entry address, port value
//   CLEAR               invalidate every entry (any state)
//   LK_REQ, LK_DEST     per-channel lookup request and destination (packed)
//   LK_VALID, LK_PORT,
//   LK_MISS             per-channel registered lookup result (packed)
//   READY               high while in RUN
//   ENTRY_CNT           number of valid entries

// One lookup channel: registers the resolved port for a single request.
module route_table_lane #(
    parameter int DEST_W       = 4,
    parameter int PORT_W       = 3,
    parameter int TBL          = 16,
    parameter int DEFAULT_PORT = 0
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       run,
    input  logic                       req,
    input  logic [DEST_W-1:0]          dest,
    input  logic [TBL-1:0]             tbl_vld,
    input  logic [TBL-1:0][PORT_W-1:0] tbl_port,
    output logic                       vld,
    output logic [PORT_W-1:0]          port,
    output logic                       miss
);
    // Entries at or above ROUTERS_CNT are never marked valid, so the valid
    // bit alone also covers the out-of-range destination case.
    logic hit;
    assign hit = run && tbl_vld[dest];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            vld  <= 1'b0;
            port <= '0;
            miss <= 1'b0;
        end else begin
            vld <= req;
            // Port and miss flag hold their last value while idle.
            if (req) begin
                port <= hit ? tbl_port[dest] : PORT_W'(DEFAULT_PORT);
                miss <= !hit;
            end
        end
    end
endmodule

module route_table #(
    parameter int ROUTERS_CNT  = 16,
    parameter int PORT_CNT     = 5,
    parameter int LOOKUP_CNT   = 5,
    parameter int DEFAULT_PORT = 0,
    localparam int DEST_W      = $clog2(ROUTERS_CNT),
    localparam int PORT_W      = $clog2(PORT_CNT)
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         INIT,
    input  logic                         WRITE,
    input  logic [DEST_W-1:0]            LOAD,
    input  logic [PORT_W-1:0]            DATA,
    input  logic                         CLEAR,
    input  logic [LOOKUP_CNT-1:0]        LK_REQ,
    input  logic [LOOKUP_CNT*DEST_W-1:0] LK_DEST,
    output logic [LOOKUP_CNT-1:0]        LK_VALID,
    output logic [LOOKUP_CNT*PORT_W-1:0] LK_PORT,
    output logic [LOOKUP_CNT-1:0]        LK_MISS,
    output logic                         READY,
    output logic [DEST_W:0]              ENTRY_CNT
);
    // Table storage is sized to the full address space so any LOAD/LK_DEST
    // value indexes safely; the range checks become constant lookup vectors.
    localparam int TBL  = 1 << DEST_W;
    localparam int PTBL = 1 << PORT_W;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_t;

    state_t                     state_q, state_d;
    logic [TBL-1:0]             addr_ok;
    logic [PTBL-1:0]            data_ok;
    logic [TBL-1:0]             valid_q;
    logic [TBL-1:0][PORT_W-1:0] port_q;
    logic [DEST_W:0]            cnt_q;
    logic                       wr_en;
    logic                       run;

    for (genvar g = 0; g < TBL; g++) begin : g_addr_ok
        assign addr_ok[g] = (g < ROUTERS_CNT);
    end
    for (genvar g = 0; g < PTBL; g++) begin : g_data_ok
        assign data_ok[g] = (g < PORT_CNT);
    end

    // ---------------- state machine ----------------
    always_ff @(posedge CLK) begin
        if (RESET) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (INIT)  state_d = ST_LOAD;
            ST_LOAD: if (!INIT) state_d = ST_RUN;
            ST_RUN:  if (INIT)  state_d = ST_LOAD;
            default:            state_d = ST_IDLE;
        endcase
    end

    assign run   = (state_q == ST_RUN);
    assign READY = run;

    // ---------------- table write / clear ----------------
    assign wr_en = (state_q == ST_LOAD) && WRITE && addr_ok[LOAD] && data_ok[DATA];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (CLEAR) begin
                valid_q <= '0;
                cnt_q   <= '0;
            end
            // A write in the same cycle as CLEAR lands after it: the later
            // non-blocking assignment to the single bit wins.
            if (wr_en) begin
                valid_q[LOAD] <= 1'b1;
                if (CLEAR)              cnt_q <= (DEST_W+1)'(1);
                else if (!valid_q[LOAD]) cnt_q <= cnt_q + (DEST_W+1)'(1);
            end
        end
    end

    // Port values need no reset: they are only read behind a valid bit.
    always_ff @(posedge CLK) begin
        if (wr_en) port_q[LOAD] <= DATA;
    end

    assign ENTRY_CNT = cnt_q;

    // ---------------- lookup channels ----------------
    for (genvar i = 0; i < LOOKUP_CNT; i++) begin : g_lane
        route_table_lane #(
            .DEST_W      (DEST_W),
            .PORT_W      (PORT_W),
            .TBL         (TBL),
            .DEFAULT_PORT(DEFAULT_PORT)
        ) u_lane (
            .CLK     (CLK),
            .RESET   (RESET),
            .run     (run),
            .req     (LK_REQ[i]),
            .dest    (LK_DEST[i*DEST_W +: DEST_W]),
            .tbl_vld (valid_q),
            .tbl_port(port_q),
            .vld     (LK_VALID[i]),
            .port    (LK_PORT[i*PORT_W +: PORT_W]),
            .miss    (LK_MISS[i])
        );
    end
endmodule

// File: tb/tb_route_table.sv
module tb_route_table;
    logic        CLK, RESET, INIT, CLEAR;
    // main instance: 16 routers, 5 ports, 5 channels, default port 0
    logic        WRITE;
    logic [3:0]  LOAD;
    logic [2:0]  DATA;
    logic [4:0]  LK_REQ;
    logic [19:0] LK_DEST;
    logic [4:0]  LK_VALID, LK_MISS;
    logic [14:0] LK_PORT;
    logic        READY;
    logic [4:0]  ENTRY_CNT;
    // second instance: 12 routers (so ids 12..15 are out of range), default port 1
    logic        WRITE2;
    logic [3:0]  LOAD2;
    logic [2:0]  DATA2;
    logic [1:0]  LK_REQ2, LK_VALID2, LK_MISS2;
    logic [7:0]  LK_DEST2;
    logic [5:0]  LK_PORT2;
    logic        READY2;
    logic [4:0]  ENTRY_CNT2;

    int total = 0;
    int bad   = 0;

    route_table dut (
        .CLK(CLK), .RESET(RESET), .INIT(INIT), .WRITE(WRITE), .LOAD(LOAD),
        .DATA(DATA), .CLEAR(CLEAR), .LK_REQ(LK_REQ), .LK_DEST(LK_DEST),
        .LK_VALID(LK_VALID), .LK_PORT(LK_PORT), .LK_MISS(LK_MISS),
        .READY(READY), .ENTRY_CNT(ENTRY_CNT)
    );

    route_table #(.ROUTERS_CNT(12), .PORT_CNT(5), .LOOKUP_CNT(2), .DEFAULT_PORT(1)) dut2 (
        .CLK(CLK), .RESET(RESET), .INIT(INIT), .WRITE(WRITE2), .LOAD(LOAD2),
        .DATA(DATA2), .CLEAR(CLEAR), .LK_REQ(LK_REQ2), .LK_DEST(LK_DEST2),
        .LK_VALID(LK_VALID2), .LK_PORT(LK_PORT2), .LK_MISS(LK_MISS2),
        .READY(READY2), .ENTRY_CNT(ENTRY_CNT2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; INIT = 1'b0; CLEAR = 1'b0;
        WRITE = 1'b0; LOAD = '0; DATA = '0; LK_REQ = '0; LK_DEST = '0;
        WRITE2 = 1'b0; LOAD2 = '0; DATA2 = '0; LK_REQ2 = '0; LK_DEST2 = '0;
        tick(); tick();
        RESET = 1'b0;
        tick();
        total++; if (READY !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0h exp=0", READY); end
        total++; if (ENTRY_CNT !== 5'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", ENTRY_CNT); end
        total++; if ({LK_VALID, LK_PORT, LK_MISS} !== 25'd0) begin bad++;
            $display("FAIL reset_lk got=%0h/%0h/%0h exp=0", LK_VALID, LK_PORT, LK_MISS); end
        total++; if (ENTRY_CNT2 !== 5'd0) begin bad++; $display("FAIL reset_cnt2 got=%0d exp=0", ENTRY_CNT2); end
    endtask

    task automatic test_load();
        INIT = 1'b1;
        tick();                                   // IDLE -> LOAD
        WRITE = 1'b1;  LOAD = 4'd3;   DATA = 3'd2;
        WRITE2 = 1'b1; LOAD2 = 4'd13; DATA2 = 3'd3; // out of range on dut2
        tick();
        total++; if (ENTRY_CNT !== 5'd1) begin bad++; $display("FAIL load_cnt1 got=%0d exp=1", ENTRY_CNT); end
        total++; if (ENTRY_CNT2 !== 5'd0) begin bad++; $display("FAIL load_oor_cnt2 got=%0d exp=0", ENTRY_CNT2); end
        LOAD = 4'd7;   DATA = 3'd4;
        LOAD2 = 4'd11; DATA2 = 3'd2;
        tick();
        total++; if (ENTRY_CNT !== 5'd2) begin bad++; $display("FAIL load_cnt2 got=%0d exp=2", ENTRY_CNT); end
        total++; if (ENTRY_CNT2 !== 5'd1) begin bad++; $display("FAIL load_edge_cnt2 got=%0d exp=1", ENTRY_CNT2); end
        WRITE = 1'b0; WRITE2 = 1'b0;
    endtask

    task automatic test_load_state_miss();
        LK_REQ = 5'b00001; LK_DEST[3:0] = 4'd3;
        tick();
        total++; if (LK_VALID !== 5'b00001) begin bad++; $display("FAIL ldmiss_valid got=%b exp=00001", LK_VALID); end
        total++; if (LK_MISS[0] !== 1'b1 || LK_PORT[2:0] !== 3'd0) begin bad++;
            $display("FAIL ldmiss_ch0 got miss=%b port=%0d exp miss=1 port=0", LK_MISS[0], LK_PORT[2:0]); end
        LK_REQ = '0;
        WRITE = 1'b1; LOAD = 4'd3; DATA = 3'd5;   // DATA >= PORT_CNT: ignored
        tick();
        WRITE = 1'b0;
        total++; if (ENTRY_CNT !== 5'd2) begin bad++; $display("FAIL baddata_cnt got=%0d exp=2", ENTRY_CNT); end
        INIT = 1'b0;
        tick();                                   // LOAD -> RUN
        total++; if (READY !== 1'b1) begin bad++; $display("FAIL run_ready got=%b exp=1", READY); end
    endtask

    task automatic test_lookup_hit();
        LK_REQ = 5'b10001; LK_DEST[3:0] = 4'd3; LK_DEST[19:16] = 4'd7;
        LK_REQ2 = 2'b11;   LK_DEST2[3:0] = 4'd13; LK_DEST2[7:4] = 4'd11;
        tick();
        total++; if (LK_VALID !== 5'b10001) begin bad++; $display("FAIL hit_valid got=%b exp=10001", LK_VALID); end
        total++; if (LK_PORT !== 15'h4002) begin bad++; $display("FAIL hit_port got=%h exp=4002", LK_PORT); end
        total++; if (LK_MISS !== 5'b00000) begin bad++; $display("FAIL hit_miss got=%b exp=00000", LK_MISS); end
        total++; if (LK_VALID2 !== 2'b11 || LK_MISS2 !== 2'b01 || LK_PORT2 !== 6'o21) begin bad++;
            $display("FAIL oor_lookup2 got v=%b m=%b p=%o exp v=11 m=01 p=21", LK_VALID2, LK_MISS2, LK_PORT2); end
        LK_REQ = '0; LK_REQ2 = '0;
        tick();
        total++; if (LK_VALID !== 5'b0 || LK_PORT !== 15'h4002) begin bad++;
            $display("FAIL idle_hold got v=%b p=%h exp v=00000 p=4002", LK_VALID, LK_PORT); end
    endtask

    task automatic test_miss();
        LK_REQ = 5'b00110; LK_DEST[7:4] = 4'd5; LK_DEST[11:8] = 4'd15;
        tick();
        total++; if (LK_VALID !== 5'b00110) begin bad++; $display("FAIL miss_valid got=%b exp=00110", LK_VALID); end
        total++; if (LK_MISS !== 5'b00110) begin bad++; $display("FAIL miss_flags got=%b exp=00110", LK_MISS); end
        total++; if (LK_PORT !== 15'h4002) begin bad++; $display("FAIL miss_port got=%h exp=4002", LK_PORT); end
        LK_REQ = '0;
    endtask

    task automatic test_reconfig();
        INIT = 1'b1; LK_REQ = 5'b00001; LK_DEST[3:0] = 4'd3;
        tick();                                   // RUN -> LOAD, request still in RUN
        total++; if (LK_PORT[2:0] !== 3'd2 || LK_MISS[0] !== 1'b0) begin bad++;
            $display("FAIL initrise_hit got p=%0d m=%b exp p=2 m=0", LK_PORT[2:0], LK_MISS[0]); end
        total++; if (READY !== 1'b0) begin bad++; $display("FAIL reload_ready got=%b exp=0", READY); end
        LK_REQ = '0; WRITE = 1'b1; LOAD = 4'd3; DATA = 3'd1;
        tick();
        WRITE = 1'b0; INIT = 1'b0;
        total++; if (ENTRY_CNT !== 5'd2) begin bad++; $display("FAIL overwrite_cnt got=%0d exp=2", ENTRY_CNT); end
        tick();                                   // LOAD -> RUN
        LK_REQ = 5'b00001;
        tick();
        total++; if (LK_PORT[2:0] !== 3'd1 || LK_MISS[0] !== 1'b0) begin bad++;
            $display("FAIL rewrite_hit got p=%0d m=%b exp p=1 m=0", LK_PORT[2:0], LK_MISS[0]); end
        LK_REQ = '0;
    endtask

    task automatic test_clear_write();
        INIT = 1'b1;
        tick();                                   // RUN -> LOAD
        CLEAR = 1'b1; WRITE = 1'b1; LOAD = 4'd9; DATA = 3'd3;
        tick();
        CLEAR = 1'b0; WRITE = 1'b0; INIT = 1'b0;
        total++; if (ENTRY_CNT !== 5'd1) begin bad++; $display("FAIL clrwr_cnt got=%0d exp=1", ENTRY_CNT); end
        total++; if (ENTRY_CNT2 !== 5'd0) begin bad++; $display("FAIL clr_cnt2 got=%0d exp=0", ENTRY_CNT2); end
        tick();                                   // LOAD -> RUN
        LK_REQ = 5'b00011; LK_DEST[3:0] = 4'd9; LK_DEST[7:4] = 4'd7;
        tick();
        total++; if (LK_VALID !== 5'b00011) begin bad++; $display("FAIL clr_valid got=%b exp=00011", LK_VALID); end
        total++; if (LK_PORT[5:0] !== 6'o03 || LK_MISS[1:0] !== 2'b10) begin bad++;
            $display("FAIL clr_lookup got p=%o m=%b exp p=03 m=10", LK_PORT[5:0], LK_MISS[1:0]); end
        LK_REQ = '0;
    endtask

    task automatic test_back_to_back();
        logic [14:0] exp_port;
        logic [4:0]  exp_miss;
        LK_REQ = 5'b11111;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 5; i++) begin
                if ((i + k) % 2 == 0) begin
                    LK_DEST[i*4 +: 4] = 4'd9;       exp_port[i*3 +: 3] = 3'd3; exp_miss[i] = 1'b0;
                end else begin
                    LK_DEST[i*4 +: 4] = 4'(i + k);  exp_port[i*3 +: 3] = 3'd0; exp_miss[i] = 1'b1;
                end
            end
            tick();
            total++; if (LK_VALID !== 5'b11111 || LK_PORT !== exp_port || LK_MISS !== exp_miss) begin bad++;
                $display("FAIL b2b_cycle%0d got v=%b p=%h m=%b exp v=11111 p=%h m=%b",
                         k, LK_VALID, LK_PORT, LK_MISS, exp_port, exp_miss); end
        end
        RESET = 1'b1;                             // requests still asserted
        tick();
        RESET = 1'b0; LK_REQ = '0;
        total++; if ({LK_VALID, LK_PORT, LK_MISS} !== 25'd0) begin bad++;
            $display("FAIL midreset_lk got v=%b p=%h m=%b exp 0", LK_VALID, LK_PORT, LK_MISS); end
        total++; if (READY !== 1'b0 || ENTRY_CNT !== 5'd0) begin bad++;
            $display("FAIL midreset_state got ready=%b cnt=%0d exp 0/0", READY, ENTRY_CNT); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_load_state_miss();
        test_lookup_hit();
        test_miss();
        test_reconfig();
        test_clear_write();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
